// File: rtl/secded_mem_engine.sv
// -----------------------------------------------------------------------------
// secded_mem_engine
//
// Purpose:
//   Walks a block of N_WORDS 16-bit words stored as little-endian byte pairs
//   in a byte-wide data memory. Each word is read and transformed, and the
//   result is written back to a destination block. There is one word every
//   five clocks (RD_LO, RD_HI, CALC, WR_LO, WR_HI).
//     mode 0 : encode an 11-bit message (word[10:0]) into a 16-bit Hamming
//              SECDED codeword.
//     mode 1 : decode a codeword. Single errors are corrected and double
//              errors are detected. The output is {flags[4:0], data[10:0]}
//              with flags 5'b01000 for a corrected word and 5'b10000 for a
//              detected double error.
//
//   Codeword layout (bit: content):
//     0:p0  1:p1  2:p2  3:d1  4:p4  7..5:d4..d2  8:p8  15..9:d11..d5
//   p0 is the overall parity over bits 15..1.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset. It also aborts a run in
//              progress; bytes that are already written stay in memory.
//   start      begins a run. It is sampled only in IDLE or DONE.
//   mode       0 = encode, 1 = decode. It is latched when start is accepted.
//   done       level output, held high in DONE until the next start
//   busy       high while a run is in progress
//   mem_addr   data-memory byte address
//   mem_we     write strobe. It is high only in WR_LO and WR_HI.
//   mem_wdata  write byte
//   mem_rdata  read byte, valid one clock after mem_addr (synchronous read)
//   sgl_cnt    single errors corrected in this run (saturating)
//   dbl_cnt    double errors detected in this run (saturating)
// -----------------------------------------------------------------------------
module secded_mem_engine #(
  parameter int N_WORDS  = 15,
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int CNT_W    = $clog2(N_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [CNT_W-1:0]  sgl_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CALC  = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               mode_reg;
  logic [7:0]         lo_byte_reg;
  logic [15:0]        result_reg;
  logic [CNT_W-1:0]   sgl_cnt_reg;
  logic [CNT_W-1:0]   dbl_cnt_reg;

  logic               start_accept;
  logic               last_word;

  // ---------------------------------------------------------------------------
  // Address generation. The arithmetic wraps modulo 2^ADDR_W.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]  word_off;
  logic [ADDR_W-1:0]  src_lo, src_hi, dst_lo, dst_hi;

  assign word_off = ADDR_W'({idx_reg, 1'b0});
  assign src_lo   = ADDR_W'(SRC_BASE) + word_off;
  assign src_hi   = src_lo + ADDR_W'(1);
  assign dst_lo   = ADDR_W'(DST_BASE) + word_off;
  assign dst_hi   = dst_lo + ADDR_W'(1);

  assign start_accept = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_word    = (idx_reg == IDX_W'(N_WORDS - 1));

  // ---------------------------------------------------------------------------
  // Datapath. The complete word exists only in CALC: the high byte is
  // arriving on mem_rdata and the low byte was captured one clock earlier.
  // ---------------------------------------------------------------------------
  logic [15:0] fetched_word;
  assign fetched_word = {mem_rdata, lo_byte_reg};

  // Encoder
  logic [11:1] enc_d;
  logic        enc_p8, enc_p4, enc_p2, enc_p1, enc_p0;
  logic [15:0] enc_cw;

  assign enc_d  = fetched_word[10:0];
  assign enc_p8 = ^enc_d[11:5];
  assign enc_p4 = (^enc_d[11:8]) ^ (^enc_d[4:2]);
  assign enc_p2 = enc_d[11] ^ enc_d[10] ^ enc_d[7] ^ enc_d[6] ^ enc_d[4] ^ enc_d[3] ^ enc_d[1];
  assign enc_p1 = enc_d[11] ^ enc_d[9] ^ enc_d[7] ^ enc_d[5] ^ enc_d[4] ^ enc_d[2] ^ enc_d[1];
  assign enc_p0 = (^enc_d) ^ enc_p8 ^ enc_p4 ^ enc_p2 ^ enc_p1;
  assign enc_cw = {enc_d[11:5], enc_p8, enc_d[4:2], enc_p4, enc_d[1], enc_p2, enc_p1, enc_p0};

  // Decoder. The syndrome is the XOR of the positions of all set bits, so a
  // single flipped bit at position k gives syndrome k. Bit 0 is excluded
  // because it only contributes to the overall parity.
  logic [3:0]  syn_term [16];
  logic [3:0]  syndrome;
  logic        dec_parity;
  logic        dec_single;
  logic        dec_double;
  logic [15:0] dec_flip_mask;
  logic [15:0] dec_fixed;
  logic [10:0] dec_data;
  logic [4:0]  dec_flags;
  logic [15:0] dec_result;

  assign syn_term[0] = 4'd0;

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_syn
      assign syn_term[gi] = fetched_word[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  always_comb begin
    syndrome = 4'd0;
    for (int k = 0; k < 16; k++) begin
      syndrome = syndrome ^ syn_term[k];
    end
  end

  // An odd overall parity means exactly one bit is flipped. Syndrome 0 in
  // that case means the flipped bit is p0 itself, so the shift gives bit 0.
  assign dec_parity    = ^fetched_word;
  assign dec_single    = dec_parity;
  assign dec_double    = !dec_parity && (syndrome != 4'd0);
  assign dec_flip_mask = 16'd1 << syndrome;
  assign dec_fixed     = dec_single ? (fetched_word ^ dec_flip_mask) : fetched_word;
  assign dec_data      = {dec_fixed[15:9], dec_fixed[7:5], dec_fixed[3]};
  assign dec_flags     = dec_single ? 5'b01000 : (dec_double ? 5'b10000 : 5'b00000);
  assign dec_result    = {dec_flags, dec_data};

  // ---------------------------------------------------------------------------
  // FSM: state register and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      mode_reg    <= 1'b0;
      lo_byte_reg <= 8'd0;
      result_reg  <= 16'd0;
      sgl_cnt_reg <= '0;
      dbl_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;

      if (start_accept) begin
        mode_reg    <= mode;
        sgl_cnt_reg <= '0;
        dbl_cnt_reg <= '0;
      end

      // During RD_HI, the data that was addressed in RD_LO is on mem_rdata.
      if (state_reg == RD_HI) begin
        lo_byte_reg <= mem_rdata;
      end

      if (state_reg == CALC) begin
        result_reg <= mode_reg ? dec_result : enc_cw;
        if (mode_reg && dec_single && (sgl_cnt_reg != {CNT_W{1'b1}})) begin
          sgl_cnt_reg <= sgl_cnt_reg + CNT_W'(1);
        end
        if (mode_reg && dec_double && (dbl_cnt_reg != {CNT_W{1'b1}})) begin
          dbl_cnt_reg <= dbl_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next   = '0;
          state_next = RD_LO;
        end
      end

      RD_LO: begin
        busy       = 1'b1;
        mem_addr   = src_lo;
        state_next = RD_HI;
      end

      RD_HI: begin
        busy       = 1'b1;
        mem_addr   = src_hi;
        state_next = CALC;
      end

      CALC: begin
        busy       = 1'b1;
        state_next = WR_LO;
      end

      WR_LO: begin
        busy       = 1'b1;
        mem_addr   = dst_lo;
        mem_we     = 1'b1;
        mem_wdata  = result_reg[7:0];
        state_next = WR_HI;
      end

      WR_HI: begin
        busy      = 1'b1;
        mem_addr  = dst_hi;
        mem_we    = 1'b1;
        mem_wdata = result_reg[15:8];
        if (last_word) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = RD_LO;
        end
      end

      DONE: begin
        done = 1'b1;
        if (start) begin
          idx_next   = '0;
          state_next = RD_LO;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sgl_cnt = sgl_cnt_reg;
  assign dbl_cnt = dbl_cnt_reg;

endmodule

// File: tb/tb_secded_mem_engine.sv
// -----------------------------------------------------------------------------
// tb_secded_mem_engine
//
// Tests secded_mem_engine against a byte-wide synchronous-read memory model.
// The expected outputs come from a generic Hamming reference model. In this
// model, data occupies the non-power-of-two positions, the parity bit at
// position 2^j covers positions that have bit j set, and p0 is the overall
// parity. The bench prints one line per word that it compares.
// -----------------------------------------------------------------------------
module tb_secded_mem_engine;

  localparam int N      = 15;
  localparam int ADDR_W = 8;
  localparam int SRC    = 30;
  localparam int DST    = 0;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int LAT    = 5 * N + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [CNT_W-1:0]  sgl_cnt;
  logic [CNT_W-1:0]  dbl_cnt;

  always #5 clk = ~clk;

  secded_mem_engine #(
    .N_WORDS (N),
    .ADDR_W  (ADDR_W),
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .done     (done),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .sgl_cnt  (sgl_cnt),
    .dbl_cnt  (dbl_cnt)
  );

  // Memory model with a synchronous read. The bench writes to it through
  // its own port, and only while the engine is idle.
  logic [7:0]        mem [256];
  logic              tb_we;
  logic [ADDR_W-1:0] tb_addr;
  logic [7:0]        tb_wdata;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] src_words [N];
  logic [15:0] exp_words [N];
  int          exp_sgl;
  int          exp_dbl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic logic is_pow2(input int k);
    return (k & (k - 1)) == 0;
  endfunction

  function automatic logic [15:0] ref_encode(input logic [15:0] w);
    logic [15:0] cw;
    int          di;
    int          pos;
    logic        p;
    cw = 16'd0;
    di = 0;
    for (int k = 1; k < 16; k++) begin
      if (!is_pow2(k)) begin
        cw[k[3:0]] = w[di[3:0]];
        di++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) begin
        if (((k >> j) & 1) == 1) p = p ^ cw[k[3:0]];
      end
      pos = 1 << j;
      cw[pos[3:0]] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  // kind: 0 = clean, 1 = corrected single error, 2 = detected double error
  function automatic logic [15:0] ref_decode(input logic [15:0] cw, output int kind);
    int          s;
    logic        par;
    logic [15:0] fixed;
    logic [15:0] d;
    int          di;
    s = 0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k[3:0]]) s = s ^ k;
    end
    par   = ^cw;
    fixed = cw;
    if (par) fixed[s[3:0]] = ~fixed[s[3:0]];
    kind = par ? 1 : ((s != 0) ? 2 : 0);
    d  = 16'd0;
    di = 0;
    for (int k = 1; k < 16; k++) begin
      if (!is_pow2(k)) begin
        d[di[3:0]] = fixed[k[3:0]];
        di++;
      end
    end
    return {(kind == 1) ? 5'b01000 : ((kind == 2) ? 5'b10000 : 5'b00000), d[10:0]};
  endfunction

  // Returns a random codeword with 0, 1 or 2 bits flipped at distinct positions.
  function automatic logic [15:0] rand_codeword();
    logic [15:0] cw;
    int          e;
    int          a;
    int          b;
    cw = ref_encode(16'($urandom()));
    e  = $urandom_range(0, 2);
    a  = $urandom_range(0, 15);
    b  = (a + $urandom_range(1, 15)) % 16;
    if (e >= 1) cw[a[3:0]] = ~cw[a[3:0]];
    if (e == 2) cw[b[3:0]] = ~cw[b[3:0]];
    return cw;
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic poke(input int addr, input logic [7:0] data);
    tb_addr  = addr[ADDR_W-1:0];
    tb_wdata = data;
    tb_we    = 1'b1;
    @(negedge clk);
    tb_we    = 1'b0;
  endtask

  // Loads src_words into memory, fills the destination with a marker value
  // and computes the expected outputs.
  task automatic load_and_model(input logic m);
    int kind;
    exp_sgl = 0;
    exp_dbl = 0;
    for (int i = 0; i < N; i++) begin
      poke(SRC + 2 * i, src_words[i][7:0]);
      poke(SRC + 2 * i + 1, src_words[i][15:8]);
      poke(DST + 2 * i, 8'hEE);
      poke(DST + 2 * i + 1, 8'hEE);
      if (m == 1'b0) begin
        exp_words[i] = ref_encode(src_words[i]);
      end else begin
        exp_words[i] = ref_decode(src_words[i], kind);
        if (kind == 1) exp_sgl++;
        if (kind == 2) exp_dbl++;
      end
    end
  endtask

  // Starts a run and waits for done within a bounded number of cycles.
  // Cycle 1 is the first cycle after the edge that samples start. If
  // pulse_at is nonzero, start is pulsed again and mode is toggled at that
  // cycle.
  task automatic run_engine(input string tag, input logic m, input int pulse_at);
    int cyc;
    int done_cyc;
    done_cyc = -1;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy"}, busy, 1);
    while (cyc <= 3 * LAT) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == pulse_at) begin
        start = 1'b1;
        mode  = ~m;
      end else begin
        start = 1'b0;
        mode  = m;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, LAT);
  endtask

  task automatic verify(input string tag);
    logic [15:0] got;
    for (int i = 0; i < N; i++) begin
      got = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
      $display("%s word %0d in=%h out=%h exp=%h", tag, i, src_words[i], got, exp_words[i]);
      check($sformatf("%s_w%0d", tag, i), got, exp_words[i]);
    end
    check({tag, "_sgl"}, sgl_cnt, exp_sgl);
    check({tag, "_dbl"}, dbl_cnt, exp_dbl);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int cyc;
    int writes;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    tb_we    = 1'b0;
    tb_addr  = '0;
    tb_wdata = 8'd0;
    repeat (3) @(negedge clk);

    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_sgl", sgl_cnt, 0);
    check("rst_dbl", dbl_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Encode. The upper five input bits must be ignored.
    src_words[0] = 16'h05A5;
    src_words[1] = 16'hFDA5;
    for (int i = 2; i < N; i++) src_words[i] = 16'($urandom());
    load_and_model(1'b0);
    run_engine("enc", 1'b0, 0);
    verify("enc");
    check("enc_05A5", {mem[DST + 1], mem[DST]}, 16'hB44B);
    check("enc_upper_ignored", {mem[DST + 3], mem[DST + 2]}, 16'hB44B);
    check("enc_done_level", done, 1);

    // Decode of clean codewords
    for (int i = 0; i < N; i++) src_words[i] = ref_encode(16'($urandom()));
    load_and_model(1'b1);
    run_engine("dec_clean", 1'b1, 0);
    verify("dec_clean");

    // Single-error sweep over bit positions 0..14 of codeword 0xB44B
    for (int i = 0; i < N; i++) src_words[i] = 16'hB44B ^ (16'd1 << i);
    load_and_model(1'b1);
    run_engine("sweep", 1'b1, 0);
    verify("sweep");
    for (int i = 0; i < N; i++) begin
      check($sformatf("sweep_const_b%0d", i), {mem[DST + 2 * i + 1], mem[DST + 2 * i]}, 16'h45A5);
    end
    check("sweep_sgl_const", sgl_cnt, N);

    // Mixed errors, including a fixed double error and a bit-15 single error
    for (int i = 0; i < N; i++) src_words[i] = rand_codeword();
    src_words[0]     = 16'hB44B ^ 16'h0208;
    src_words[N - 1] = 16'hB44B ^ 16'h8000;
    load_and_model(1'b1);
    run_engine("mixed", 1'b1, 0);
    verify("mixed");
    check("mixed_dbl_word", {mem[DST + 1], mem[DST]}, 16'h85B4);
    check("mixed_b15_word", {mem[DST + 2 * N - 1], mem[DST + 2 * N - 2]}, 16'h45A5);

    // A start pulse and a mode change in the middle of a run are ignored.
    for (int i = 0; i < N; i++) src_words[i] = 16'($urandom());
    load_and_model(1'b0);
    run_engine("restart_ignored", 1'b0, 20);
    verify("restart_ignored");

    // Reset in the middle of a run
    for (int i = 0; i < N; i++) src_words[i] = rand_codeword();
    load_and_model(1'b1);
    @(negedge clk);
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sgl", sgl_cnt, 0);
    check("midrst_dbl", dbl_cnt, 0);
    check("midrst_addr", mem_addr, 0);
    writes = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_we) writes++;
    end
    check("midrst_no_writes", writes, 0);

    // A new run after the reset completes normally.
    for (int i = 0; i < N; i++) src_words[i] = rand_codeword();
    load_and_model(1'b1);
    run_engine("after_rst", 1'b1, 0);
    verify("after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
